i2c_master_read_sequencer: RTL
==============================

# i2c_master_read_sequencer

Multi-byte read sequencer for the I2C master datapath, sitting directly downstream of the byte-read stage and alongside the ACK bit writer. It drives the byte reader's `go`, assembles the serial bits it reports (`data` qualified by `load`) MSB-first into bytes, then commands an ACK after every byte except the last, which gets a NACK. Completed bytes are presented on a valid/ready holding register. The sequencer stalls the bus between bytes while that register is full.

## Interface
- No parameters.
- `clock` in 1: system clock; all state on rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `start` in 1: one-cycle request to begin a read of `length` bytes; ignored while `busy`.
- `length` in 8: number of bytes to read, latched with `start`; 0 means no bus activity.
- `rd_go` out 1: enable to the byte reader.
- `rd_data` in 1: bit value from the byte reader.
- `rd_load` in 1: bit-valid strobe from the byte reader.
- `rd_finish` in 1: byte-complete strobe; coincides with `rd_load` of bit 0.
- `rd_error` in 1: byte-reader error.
- `ack_go` out 1: enable to the ACK bit writer.
- `ack_nack` out 1: bit to drive, 0=ACK, 1=NACK; valid while `ack_go`.
- `ack_finish` in 1: ACK bit done.
- `ack_error` in 1: ACK writer error.
- `out_data` out 8: received byte.
- `out_valid` out 1: `out_data` holds an unconsumed byte.
- `out_ready` in 1: consumer accepts when `out_valid && out_ready`.
- `busy` out 1: sequence in progress.
- `done` out 1: one-cycle pulse on successful completion.
- `error` out 1: one-cycle pulse on abort.
- `byte_count` out 8: bytes received in the current or last sequence.

## Operation
- Reset values: all outputs 0, state IDLE, shift register 0, remaining count 0.
- States: IDLE, READ, ACK, WAIT, ERR.
- **IDLE**
  - `start && length!=0` → READ, latching `remaining=length`, clearing `byte_count` and the shift register.
  - `start && length==0` → pulse `done` next cycle and stay IDLE.
- **READ**
  - `rd_go=1`.
  - On each `rd_load`, `shift <= {shift[6:0], rd_data}`.
  - On `rd_finish`:
    - `out_data <= {shift[6:0], rd_data}`, `out_valid <= 1`.
    - `byte_count++`, `remaining--`.
    - → ACK.
  - `rd_error` has priority over `rd_finish` → ERR; the partial byte is discarded.
- **ACK**
  - `ack_go=1`, `ack_nack = (remaining==0)`.
  - `ack_error` → ERR.
  - On `ack_finish`:
    - `remaining==0` → IDLE and pulse `done`.
    - else `out_valid` still set (after this cycle's handshake) → WAIT.
    - else → READ, with the shift register cleared.
- **WAIT**: no go asserted; when `out_valid==0` → READ.
- **ERR**: pulse `error` for one cycle → IDLE. `out_valid`/`out_data` are retained for the consumer.
- `busy=1` in READ, ACK, WAIT and ERR.
- Holding register: `out_valid` clears on `out_valid && out_ready`. Because READ is entered only with the register empty, a load never overwrites an unconsumed byte.
- `start` while busy: ignored, with no effect on `length` or the count.
- Reset mid-operation returns everything to reset values immediately; go outputs drop asynchronously.

## Timing
- All outputs are registered, or decoded from registered state only; no input-to-output combinational path.
- `start` sampled at edge N → `rd_go`/`busy` high from N+1.
- `rd_finish` at edge M → `out_valid` and `ack_go` high from M+1; `rd_go` low from M+1, so the byte reader sees `go` drop one cycle after its finish.
- `ack_finish` at edge K:
  - next byte's `rd_go` from K+1 if the holding register is empty;
  - otherwise `rd_go` one cycle after the handshake clears `out_valid`.
- `done`/`error` are high exactly one cycle, the cycle the state returns to IDLE (`done` asserts together with the last `ack_go` deassertion).
- `rd_go` and `ack_go` are never high in the same cycle.

## Test plan
- **Single byte:** `length=1`, bits 1,0,1,0,0,1,0,1 → `out_data=0xA5`, `out_valid` one cycle after `rd_finish`, `ack_nack=1`, `done` pulse, `byte_count=1`.
- **Three bytes, `out_ready` tied high:** bytes 0x01, 0xFF, 0x3C → values and order match; `ack_nack` is 0, 0, 1; `byte_count=3`; no WAIT entry.
- **Backpressure:** `length=2`, `out_ready=0` until 20 cycles after the first ACK → state stays in WAIT with `rd_go=0`; `rd_go` rises one cycle after the handshake; the second byte is correct.
- **Error mid-byte:** `rd_error` after 4 bits of byte 2 → `error` pulse, `busy` drops, the previous byte stays valid, `byte_count=1`; `ack_error` on byte 1 is handled the same way.
- **Corner cases:**
  - `length=0` → `done` pulse and no `rd_go`.
  - `start` during READ → ignored.
  - `reset_n` low mid-ACK → all outputs 0 and state IDLE immediately.

Source files
------------

// File: rtl/i2c_master_read_sequencer_if.sv
// Bus bundle between the multi-byte read sequencer, its byte reader, ACK writer,
// the command source and the holding-register consumer.
interface i2c_master_read_sequencer_if;
  localparam int unsigned BYTE_W = 8;

  logic              start;
  logic [BYTE_W-1:0] length;
  logic              rd_go;
  logic              rd_data;
  logic              rd_load;
  logic              rd_finish;
  logic              rd_error;
  logic              ack_go;
  logic              ack_nack;
  logic              ack_finish;
  logic              ack_error;
  logic [BYTE_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic              busy;
  logic              done;
  logic              error;
  logic [BYTE_W-1:0] byte_count;

  modport master (
    input  start, length, rd_data, rd_load, rd_finish, rd_error,
           ack_finish, ack_error, out_ready,
    output rd_go, ack_go, ack_nack, out_data, out_valid, busy, done, error,
           byte_count
  );

  modport slave (
    output start, length, rd_data, rd_load, rd_finish, rd_error,
           ack_finish, ack_error, out_ready,
    input  rd_go, ack_go, ack_nack, out_data, out_valid, busy, done, error,
           byte_count
  );
endinterface

// File: rtl/i2c_master_read_sequencer.sv
// Multi-byte I2C read sequencer: assembles bytes from the byte reader, ACKs all
// but the last byte, and parks between bytes while the holding register is full.
module i2c_master_read_sequencer (
  input  logic                           clock,
  input  logic                           reset_n,
  i2c_master_read_sequencer_if.master    bus
);
  localparam int unsigned BYTE_W = 8;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_READ = 3'd1,
    S_ACK  = 3'd2,
    S_WAIT = 3'd3,
    S_ERR  = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [BYTE_W-1:0] shift_q, shift_d;
  logic [BYTE_W-1:0] remaining_q, remaining_d;
  logic [BYTE_W-1:0] count_q, count_d;
  logic [BYTE_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic              rd_go_q, rd_go_d;
  logic              ack_go_q, ack_go_d;
  logic              nack_q, nack_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              error_q, error_d;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      shift_q     <= '0;
      remaining_q <= '0;
      count_q     <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      rd_go_q     <= 1'b0;
      ack_go_q    <= 1'b0;
      nack_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      remaining_q <= remaining_d;
      count_q     <= count_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      rd_go_q     <= rd_go_d;
      ack_go_q    <= ack_go_d;
      nack_q      <= nack_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      error_q     <= error_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    remaining_d = remaining_q;
    count_d     = count_q;
    data_d      = data_q;
    valid_d     = valid_q && !bus.out_ready;
    done_d      = 1'b0;
    error_d     = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          if (bus.length != '0) begin
            state_d     = S_READ;
            remaining_d = bus.length;
            count_d     = '0;
            shift_d     = '0;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      S_READ: begin
        // Error wins over a coincident finish; the partial byte is dropped.
        if (bus.rd_error) begin
          state_d = S_ERR;
        end else if (bus.rd_finish) begin
          shift_d     = {shift_q[BYTE_W-2:0], bus.rd_data};
          data_d      = {shift_q[BYTE_W-2:0], bus.rd_data};
          valid_d     = 1'b1;
          count_d     = BYTE_W'(count_q + BYTE_W'(1));
          remaining_d = BYTE_W'(remaining_q - BYTE_W'(1));
          state_d     = S_ACK;
        end else if (bus.rd_load) begin
          shift_d = {shift_q[BYTE_W-2:0], bus.rd_data};
        end
      end
      S_ACK: begin
        if (bus.ack_error) begin
          state_d = S_ERR;
        end else if (bus.ack_finish) begin
          if (remaining_q == '0) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else begin
            shift_d = '0;
            state_d = valid_d ? S_WAIT : S_READ;
          end
        end
      end
      S_WAIT: begin
        if (!valid_q) state_d = S_READ;
      end
      S_ERR: begin
        state_d = S_IDLE;
        error_d = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Strobes are registered copies of the next-state decode.
  always_comb begin
    rd_go_d  = (state_d == S_READ);
    ack_go_d = (state_d == S_ACK);
    nack_d   = (state_d == S_ACK) && (remaining_d == '0);
    busy_d   = (state_d != S_IDLE);
  end

  assign bus.rd_go      = rd_go_q;
  assign bus.ack_go     = ack_go_q;
  assign bus.ack_nack   = nack_q;
  assign bus.out_data   = data_q;
  assign bus.out_valid  = valid_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.error      = error_q;
  assign bus.byte_count = count_q;
endmodule
